// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU in
//   the execute stage. Multiplies use radix-2 shift-add into a 2N-bit product.
//   Divides use restoring division, one quotient bit per cycle.
//   Divide-by-zero and signed overflow bypass the iteration and complete one
//   cycle after acceptance.
//
//   Optional build macro: MULDIV_EARLY_OUT_EN
//     When defined, a multiply leaves CALC as soon as the remaining multiplier
//     magnitude bits are all zero. A zero multiplier skips CALC entirely.
//     Divides are unaffected.
//
// Ports
//   clk     : clock; all state updates on the rising edge
//   rst_n   : synchronous active-low reset
//   start   : request a new operation; honoured only while ready=1
//   flush   : abort the in-flight operation; wins over start
//   op      : 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   a, b    : rs1 / rs2 operands
//   ready   : high in IDLE and DONE
//   busy    : high in CALC and FIX
//   done    : one-cycle pulse, result valid
//   result  : registered result, held until the next accepted start
//   status  : {n, z} flags of result
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         flush,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [1:0]   status
);

  localparam int CW = $clog2(N + 1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Two's complement negation of an N-bit value.
  function automatic logic [N-1:0] neg_n(input logic [N-1:0] x);
    return ~x + {{(N-1){1'b0}}, 1'b1};
  endfunction

  // Two's complement negation of a 2N-bit value.
  function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] x);
    return ~x + {{(2*N-1){1'b0}}, 1'b1};
  endfunction

  // ALU-compatible {negative, zero} flags.
  function automatic logic [1:0] flags_of(input logic [N-1:0] x);
    return {x[N-1], (x == {N{1'b0}})};
  endfunction

  state_e           state_q,  state_d;
  logic [2:0]       op_q,     op_d;
  logic             neg_a_q,  neg_a_d;
  logic             neg_b_q,  neg_b_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [2*N-1:0]   prod_q,   prod_d;
  logic [2*N-1:0]   mcand_q,  mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [N:0]       rem_q,    rem_d;
  logic [N-1:0]     quo_q,    quo_d;
  logic [N-1:0]     dvsr_q,   dvsr_d;
  logic [N-1:0]     result_q, result_d;
  logic [1:0]       status_q, status_d;
  logic             ready_q,  ready_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  // Acceptance-time operand conditioning
  logic             sgn_a_s, sgn_b_s, neg_a_s, neg_b_s;
  logic [N-1:0]     abs_a_s, abs_b_s;
  logic             b_zero_s, ovf_s, fast_s;
  logic [N-1:0]     fast_res_s;
  logic             accept_early_s, calc_early_s;

  // Iteration datapath
  logic [2*N-1:0]   mul_add_s;
  logic [N+1:0]     rem_sh_s, diff_s;
  logic             ge_s;

  // Final sign correction / result select
  logic [2*N-1:0]   prod_fix_s;
  logic [N-1:0]     quo_fix_s, rem_fix_s, fix_res_s;

  // Which operands are interpreted as signed for the requested op.
  always_comb begin
    sgn_a_s = 1'b0;
    sgn_b_s = 1'b0;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        sgn_a_s = 1'b1;
        sgn_b_s = 1'b1;
      end
      OP_MULHSU: begin
        sgn_a_s = 1'b1;
        sgn_b_s = 1'b0;
      end
      default: begin
        sgn_a_s = 1'b0;
        sgn_b_s = 1'b0;
      end
    endcase
  end

  assign neg_a_s  = sgn_a_s & a[N-1];
  assign neg_b_s  = sgn_b_s & b[N-1];
  assign abs_a_s  = neg_a_s ? neg_n(a) : a;
  assign abs_b_s  = neg_b_s ? neg_n(b) : b;
  assign b_zero_s = (b == {N{1'b0}});
  // Only the signed divide/remainder can overflow: most-negative / -1.
  assign ovf_s    = ((op == OP_DIV) || (op == OP_REM)) &&
                    (a == {1'b1, {(N-1){1'b0}}}) && (b == {N{1'b1}});
  assign fast_s   = op[2] & (b_zero_s | ovf_s);

  // Fast-path result: x/0 = all ones, x%0 = x, overflow quotient = a, remainder = 0.
  always_comb begin
    fast_res_s = {N{1'b0}};
    case (op)
      OP_DIV, OP_DIVU: fast_res_s = b_zero_s ? {N{1'b1}} : a;
      OP_REM, OP_REMU: fast_res_s = b_zero_s ? a : {N{1'b0}};
      default:         fast_res_s = {N{1'b0}};
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Exit once the multiplier bits still to be consumed after this step are zero.
  assign calc_early_s   = ~op_q[2] & (mplier_q[N-1:1] == {(N-1){1'b0}});
  assign accept_early_s = ~op[2] & (abs_b_s == {N{1'b0}});
`else
  assign calc_early_s   = 1'b0;
  assign accept_early_s = 1'b0;
`endif

  assign mul_add_s = prod_q + (mplier_q[0] ? mcand_q : {(2*N){1'b0}});
  // Restoring step: shift in the next dividend bit, trial-subtract the divisor;
  // the top bit of the difference is the borrow.
  assign rem_sh_s  = {rem_q, quo_q[N-1]};
  assign diff_s    = rem_sh_s - {2'b00, dvsr_q};
  assign ge_s      = ~diff_s[N+1];

  assign prod_fix_s = (neg_a_q ^ neg_b_q) ? neg_2n(prod_q) : prod_q;
  assign quo_fix_s  = (neg_a_q ^ neg_b_q) ? neg_n(quo_q) : quo_q;
  assign rem_fix_s  = neg_a_q ? neg_n(rem_q[N-1:0]) : rem_q[N-1:0];

  // Select the architectural result for the latched op.
  always_comb begin
    fix_res_s = {N{1'b0}};
    case (op_q)
      OP_MUL:                      fix_res_s = prod_fix_s[N-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_fix_s[2*N-1:N];
      OP_DIV, OP_DIVU:             fix_res_s = quo_fix_s;
      OP_REM, OP_REMU:             fix_res_s = rem_fix_s;
      default:                     fix_res_s = {N{1'b0}};
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    count_d  = count_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    status_d = status_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (start) begin
          op_d     = op;
          neg_a_d  = neg_a_s;
          neg_b_d  = neg_b_s;
          count_d  = CW'(N);
          prod_d   = {(2*N){1'b0}};
          mcand_d  = {{N{1'b0}}, abs_a_s};
          mplier_d = abs_b_s;
          rem_d    = {(N+1){1'b0}};
          quo_d    = abs_a_s;
          dvsr_d   = abs_b_s;
          if (fast_s) begin
            result_d = fast_res_s;
            status_d = flags_of(fast_res_s);
            state_d  = S_DONE;
          end else if (accept_early_s) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          count_d = count_q - CW'(1);
          if (op_q[2]) begin
            rem_d = ge_s ? diff_s[N:0] : rem_sh_s[N:0];
            quo_d = {quo_q[N-2:0], ge_s};
          end else begin
            prod_d   = mul_add_s;
            mcand_d  = {mcand_q[2*N-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[N-1:1]};
          end
          if ((count_q == CW'(1)) || calc_early_s) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res_s;
          status_d = flags_of(fix_res_s);
          state_d  = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered from the next state.
  always_comb begin
    ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    busy_d  = (state_d == S_CALC) || (state_d == S_FIX);
    done_d  = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      count_q  <= {CW{1'b0}};
      prod_q   <= {(2*N){1'b0}};
      mcand_q  <= {(2*N){1'b0}};
      mplier_q <= {N{1'b0}};
      rem_q    <= {(N+1){1'b0}};
      quo_q    <= {N{1'b0}};
      dvsr_q   <= {N{1'b0}};
      result_q <= {N{1'b0}};
      status_q <= 2'b01;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      count_q  <= count_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      status_q <= status_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign status = status_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit (N=32). Expected results and latencies are
//   pushed when an operation is driven and popped when done is observed.
//   Latency counts cycles from the start cycle to the cycle done is high.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        ready, busy, done;
  logic [31:0] result;
  logic [1:0]  status;

  typedef struct {
    logic [31:0] res;
    int          lat;   // -1: latency not checked
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res = 32'd0;
  int          mul_lat;

  always #5 clk = ~clk;

  muldiv_unit #(.N(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .status (status)
  );

  // Drive one start and wait (bounded) for done. imm=1 drives in the current
  // cycle (used right after a done for back-to-back issue).
  task automatic drive_op(input bit imm, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat, output bit got);
    if (!imm) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    got = (done === 1'b1);
  endtask

  task automatic test_reset();
    bit seen;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready/busy/done=%b%b%b required 100", ready, busy, done);
    end
    checks++;
    if (result !== 32'd0 || status !== 2'b01) begin
      failures++;
      $display("FAIL reset_value: result=%h status=%b required 00000000/01", result, status);
    end
    rst_n = 1'b1;
    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hFFFF_FF00; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy_before: busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    rst_n = 1'b1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || result !== 32'd0 || status !== 2'b01) begin
      failures++;
      $display("FAIL reset_mid_div: ready=%b busy=%b result=%h status=%b required 1 0 00000000 01",
               ready, busy, result, status);
    end
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_no_done: done pulse seen=1 required 0");
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [6] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd3};
    logic [31:0] as  [6] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd12345, 32'h0001_0000};
    logic [31:0] bs  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'd0, 32'h0001_0000};
    logic [31:0] es  [6] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1};
    for (int i = 0; i < 6; i++) begin
      exp_t e, g;
      int lat;
      bit got;
      e.res = es[i];
      e.lat = mul_lat;
      sb_q.push_back(e);
      drive_op(1'b0, ops[i], as[i], bs[i], lat, got);
      g = sb_q.pop_front();
      last_res = g.res;
      checks++;
      if (!got || result !== g.res) begin
        failures++;
        $display("FAIL mul_result[%0d]: done=%b result=%h required %h", i, got, result, g.res);
      end
      checks++;
      if (status !== {g.res[31], g.res == 32'd0}) begin
        failures++;
        $display("FAIL mul_status[%0d]: status=%b required %b", i, status, {g.res[31], g.res == 32'd0});
      end
      if (g.lat >= 0) begin
        checks++;
        if (lat !== g.lat) begin
          failures++;
          $display("FAIL mul_latency[%0d]: latency=%0d required %0d", i, lat, g.lat);
        end
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [7] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5};
    logic [31:0] as  [7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] bs  [7] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1};
    logic [31:0] es  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      exp_t e, g;
      int lat;
      bit got;
      e.res = es[i];
      e.lat = 34;
      sb_q.push_back(e);
      drive_op(1'b0, ops[i], as[i], bs[i], lat, got);
      g = sb_q.pop_front();
      last_res = g.res;
      checks++;
      if (!got || result !== g.res) begin
        failures++;
        $display("FAIL div_result[%0d]: done=%b result=%h required %h", i, got, result, g.res);
      end
      checks++;
      if (status !== {g.res[31], g.res == 32'd0}) begin
        failures++;
        $display("FAIL div_status[%0d]: status=%b required %b", i, status, {g.res[31], g.res == 32'd0});
      end
      checks++;
      if (lat !== g.lat) begin
        failures++;
        $display("FAIL div_latency[%0d]: latency=%0d required %0d", i, lat, g.lat);
      end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  ops [6] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7};
    logic [31:0] as  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'd9};
    logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] es  [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd9};
    for (int i = 0; i < 6; i++) begin
      exp_t e, g;
      int lat;
      bit got;
      e.res = es[i];
      e.lat = 1;
      sb_q.push_back(e);
      drive_op(1'b0, ops[i], as[i], bs[i], lat, got);
      g = sb_q.pop_front();
      last_res = g.res;
      checks++;
      if (!got || result !== g.res || status !== {g.res[31], g.res == 32'd0}) begin
        failures++;
        $display("FAIL fast_result[%0d]: done=%b result=%h status=%b required %h", i, got, result, status, g.res);
      end
      checks++;
      if (lat !== g.lat) begin
        failures++;
        $display("FAIL fast_latency[%0d]: latency=%0d required %0d", i, lat, g.lat);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prior;
    bit seen;
    prior = last_res;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    // flush and start together: flush must win
    flush = 1'b1; start = 1'b1; op = 3'd5; a = 32'd1; b = 32'd1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_state: ready=%b busy=%b required 1 0", ready, busy);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL flush_no_done: done pulse seen=1 required 0");
    end
    checks++;
    if (result !== prior || status !== {prior[31], prior == 32'd0}) begin
      failures++;
      $display("FAIL flush_hold: result=%h status=%b required %h", result, status, prior);
    end
  endtask

  task automatic test_busy_start();
    exp_t e, g;
    int lat;
    e.res = 32'd14;
    e.lat = 34;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL busy_flag: busy=%b ready=%b required 1 0", busy, ready);
    end
    repeat (2) begin @(negedge clk); lat++; end
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    @(negedge clk);
    lat++;
    start = 1'b0; a = 32'd0; b = 32'd0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    g = sb_q.pop_front();
    last_res = g.res;
    checks++;
    if (done !== 1'b1 || result !== g.res) begin
      failures++;
      $display("FAIL busy_start_result: done=%b result=%h required %h", done, result, g.res);
    end
    checks++;
    if (lat !== g.lat) begin
      failures++;
      $display("FAIL busy_start_latency: latency=%0d required %0d", lat, g.lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [3] = '{3'd3, 3'd5, 3'd5};
    logic [31:0] as  [3] = '{32'hFFFF_FFFF, 32'd100, 32'd5};
    logic [31:0] bs  [3] = '{32'hFFFF_FFFF, 32'd7, 32'd0};
    logic [31:0] es  [3] = '{32'hFFFF_FFFE, 32'd14, 32'hFFFF_FFFF};
    int          ls  [3];
    ls[0] = mul_lat; ls[1] = 34; ls[2] = 1;
    for (int i = 0; i < 3; i++) begin
      exp_t e, g;
      int lat;
      bit got;
      e.res = es[i];
      e.lat = ls[i];
      sb_q.push_back(e);
      drive_op(i != 0, ops[i], as[i], bs[i], lat, got);
      g = sb_q.pop_front();
      last_res = g.res;
      checks++;
      if (!got || result !== g.res) begin
        failures++;
        $display("FAIL b2b_result[%0d]: done=%b result=%h required %h", i, got, result, g.res);
      end
      if (g.lat >= 0) begin
        checks++;
        if (lat !== g.lat) begin
          failures++;
          $display("FAIL b2b_latency[%0d]: latency=%0d required %0d", i, lat, g.lat);
        end
      end
    end
  endtask

`ifdef MULDIV_EARLY_OUT_EN
  task automatic test_early_out();
    logic [2:0]  ops [4] = '{3'd0, 3'd0, 3'd1, 3'd5};
    logic [31:0] as  [4] = '{32'd9, 32'd5, 32'd9, 32'd100};
    logic [31:0] bs  [4] = '{32'd3, 32'd0, 32'hFFFF_FFFD, 32'd7};
    logic [31:0] es  [4] = '{32'd27, 32'd0, 32'hFFFF_FFFF, 32'd14};
    int          ls  [4] = '{4, 2, 4, 34};
    for (int i = 0; i < 4; i++) begin
      exp_t e, g;
      int lat;
      bit got;
      e.res = es[i];
      e.lat = ls[i];
      sb_q.push_back(e);
      drive_op(1'b0, ops[i], as[i], bs[i], lat, got);
      g = sb_q.pop_front();
      last_res = g.res;
      checks++;
      if (!got || result !== g.res) begin
        failures++;
        $display("FAIL early_result[%0d]: done=%b result=%h required %h", i, got, result, g.res);
      end
      checks++;
      if (lat !== g.lat) begin
        failures++;
        $display("FAIL early_latency[%0d]: latency=%0d required %0d", i, lat, g.lat);
      end
    end
  endtask
`endif

  initial begin
`ifdef MULDIV_EARLY_OUT_EN
    mul_lat = -1;
`else
    mul_lat = 34;
`endif
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_flush();
    test_busy_start();
    test_back_to_back();
`ifdef MULDIV_EARLY_OUT_EN
    test_early_out();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
